// File: rtl/semafor_vest.sv
// West-approach traffic-light controller, third stage of the N-S-V-E ring.
// Takes the South token, runs red/yellow/green plus optional walk, hands to East.
module semafor_vest #(
  parameter logic [23:0] SEC      = 24'd10000000,
  parameter logic [7:0]  T_GALBEN = 8'd2,
  parameter logic [7:0]  T_VERDE  = 8'd29,
  parameter logic [7:0]  T_PIETON = 8'd10,
  parameter logic [7:0]  T_DONE   = 8'd1
) (
  input  logic clk,
  input  logic reset,
  input  logic intretinere,
  input  logic Continuare_s_v,
  input  logic buton_pieton,
  output logic Continuare_v_e,
  output logic Verde_auto_V,
  output logic Galben_auto_V,
  output logic Rosu_auto_V,
  output logic Verde_pieton_V,
  output logic Rosu_pieton_V
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRE    = 3'd1,
    S_GALBEN = 3'd2,
    S_VERDE  = 3'd3,
    S_PIETON = 3'd4,
    S_DONE   = 3'd5,
    S_MENT   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] presc_q;
  logic [7:0]  sec_q;
  logic        tok_prev_q, tok_pend_q;
  logic        ped_pend_q, blink_q;

  logic       rise, tick, dur_done, chg;
  logic [7:0] dur;

  assign rise = Continuare_s_v & ~tok_prev_q;
  assign tick = (presc_q == SEC - 24'd1);

  always_comb begin
    dur = 8'd1;
    case (state_q)
      S_GALBEN: dur = T_GALBEN;
      S_VERDE:  dur = T_VERDE;
      S_PIETON: dur = T_PIETON;
      S_DONE:   dur = T_DONE;
      default:  dur = 8'd1;
    endcase
  end

  assign dur_done = tick && (sec_q == dur - 8'd1);

  always_comb begin
    state_d = state_q;
    if (intretinere) begin
      state_d = S_MENT;
    end else begin
      case (state_q)
        S_IDLE:   if (rise || tok_pend_q) state_d = S_PRE;
        S_PRE:    if (dur_done) state_d = S_GALBEN;
        S_GALBEN: if (dur_done) state_d = S_VERDE;
        S_VERDE:
          if (dur_done)
            state_d = (ped_pend_q || buton_pieton) ? S_PIETON : S_DONE;
        S_PIETON: if (dur_done) state_d = S_DONE;
        S_DONE:   if (dur_done) state_d = S_IDLE;
        S_MENT:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  assign chg = (state_d != state_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      presc_q        <= '0;
      sec_q          <= '0;
      tok_prev_q     <= 1'b0;
      tok_pend_q     <= 1'b0;
      ped_pend_q     <= 1'b0;
      blink_q        <= 1'b0;
      Continuare_v_e <= 1'b0;
      Verde_auto_V   <= 1'b0;
      Galben_auto_V  <= 1'b0;
      Rosu_auto_V    <= 1'b1;
      Verde_pieton_V <= 1'b0;
      Rosu_pieton_V  <= 1'b1;
    end else begin
      state_q    <= state_d;
      tok_prev_q <= Continuare_s_v;

      // every state change restarts the timebase
      if (chg) begin
        presc_q <= '0;
        sec_q   <= '0;
      end else if (tick) begin
        presc_q <= '0;
        sec_q   <= sec_q + 8'd1;
      end else begin
        presc_q <= presc_q + 24'd1;
      end

      if (intretinere)
        tok_pend_q <= 1'b0;
      else if (state_q == S_IDLE && chg)
        tok_pend_q <= 1'b0;
      else if (rise && state_q != S_IDLE && state_q != S_MENT)
        tok_pend_q <= 1'b1;

      if (intretinere)
        ped_pend_q <= 1'b0;
      else if (state_d == S_PIETON && state_q != S_PIETON)
        ped_pend_q <= 1'b0;
      else if (buton_pieton && state_q != S_PIETON)
        ped_pend_q <= 1'b1;

      if (state_d == S_MENT && state_q != S_MENT)
        blink_q <= 1'b1;
      else if (state_q == S_MENT && tick)
        blink_q <= ~blink_q;

      Continuare_v_e <= 1'b0;
      Verde_auto_V   <= 1'b0;
      Galben_auto_V  <= 1'b0;
      Rosu_auto_V    <= 1'b0;
      Verde_pieton_V <= 1'b0;
      Rosu_pieton_V  <= 1'b0;
      case (state_q)
        S_GALBEN: begin
          Galben_auto_V <= 1'b1;
          Rosu_pieton_V <= 1'b1;
        end
        S_VERDE: begin
          Verde_auto_V  <= 1'b1;
          Rosu_pieton_V <= 1'b1;
        end
        S_PIETON: begin
          Rosu_auto_V    <= 1'b1;
          Verde_pieton_V <= 1'b1;
        end
        S_DONE: begin
          Rosu_auto_V    <= 1'b1;
          Rosu_pieton_V  <= 1'b1;
          Continuare_v_e <= 1'b1;
        end
        S_MENT: Galben_auto_V <= blink_q;
        default: begin
          Rosu_auto_V   <= 1'b1;
          Rosu_pieton_V <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_semafor_vest.sv
// Bench for semafor_vest: per-cycle expected lights from a phase/elapsed
// reference model, queued by the driver and checked by a separate monitor.
module tb_semafor_vest;

  localparam int SEC = 4;
  localparam int TG  = 2;
  localparam int TV  = 3;
  localparam int TP  = 2;
  localparam int TD  = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic intretinere = 1'b0;
  logic Continuare_s_v = 1'b0;
  logic buton_pieton = 1'b0;
  logic Continuare_v_e;
  logic Verde_auto_V, Galben_auto_V, Rosu_auto_V;
  logic Verde_pieton_V, Rosu_pieton_V;

  semafor_vest #(
    .SEC(24'd4), .T_GALBEN(8'd2), .T_VERDE(8'd3),
    .T_PIETON(8'd2), .T_DONE(8'd1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .intretinere(intretinere),
    .Continuare_s_v(Continuare_s_v),
    .buton_pieton(buton_pieton),
    .Continuare_v_e(Continuare_v_e),
    .Verde_auto_V(Verde_auto_V),
    .Galben_auto_V(Galben_auto_V),
    .Rosu_auto_V(Rosu_auto_V),
    .Verde_pieton_V(Verde_pieton_V),
    .Rosu_pieton_V(Rosu_pieton_V)
  );

  always #5 clk = ~clk;

  typedef enum int {P_IDLE, P_PRE, P_GAL, P_VER, P_PIE, P_DON, P_MNT} ph_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] expq[$];

  ph_t m_ph   = P_IDLE;
  int  m_el   = 0;
  bit  m_prev = 1'b0;
  bit  m_tp   = 1'b0;
  bit  m_pp   = 1'b0;

  localparam logic [5:0] RST_OUT = 6'b000101;

  function automatic logic [5:0] got_vec();
    return {Continuare_v_e, Verde_auto_V, Galben_auto_V,
            Rosu_auto_V, Verde_pieton_V, Rosu_pieton_V};
  endfunction

  function automatic int dur(ph_t p);
    case (p)
      P_PRE:   return SEC;
      P_GAL:   return TG * SEC;
      P_VER:   return TV * SEC;
      P_PIE:   return TP * SEC;
      P_DON:   return TD * SEC;
      default: return 0;
    endcase
  endfunction

  // {token, car green, car yellow, car red, walk green, walk red}
  function automatic logic [5:0] outs(ph_t p, int el);
    logic b;
    b = ((el / SEC) % 2) == 0;
    case (p)
      P_GAL:   return 6'b001001;
      P_VER:   return 6'b010001;
      P_PIE:   return 6'b000110;
      P_DON:   return 6'b100101;
      P_MNT:   return {2'b00, b, 3'b000};
      default: return RST_OUT;
    endcase
  endfunction

  task automatic model_step(input bit m, input bit tok, input bit btn);
    bit rise, fin;
    ph_t nx;
    rise = tok && !m_prev;
    fin  = (m_el + 1) == dur(m_ph);
    expq.push_back(outs(m_ph, m_el));
    nx = m_ph;
    if (m) nx = P_MNT;
    else begin
      case (m_ph)
        P_IDLE: if (rise || m_tp) nx = P_PRE;
        P_PRE:  if (fin) nx = P_GAL;
        P_GAL:  if (fin) nx = P_VER;
        P_VER:  if (fin) nx = (m_pp || btn) ? P_PIE : P_DON;
        P_PIE:  if (fin) nx = P_DON;
        P_DON:  if (fin) nx = P_IDLE;
        default: nx = P_IDLE;
      endcase
    end
    if (m) m_tp = 1'b0;
    else if (m_ph == P_IDLE && nx != P_IDLE) m_tp = 1'b0;
    else if (rise && m_ph != P_IDLE && m_ph != P_MNT) m_tp = 1'b1;
    if (m) m_pp = 1'b0;
    else if (nx == P_PIE && m_ph != P_PIE) m_pp = 1'b0;
    else if (btn && m_ph != P_PIE) m_pp = 1'b1;
    m_el   = (nx == m_ph) ? m_el + 1 : 0;
    m_prev = tok;
    m_ph   = nx;
  endtask

  task automatic step(input bit m, input bit tok, input bit btn);
    intretinere    = m;
    Continuare_s_v = tok;
    buton_pieton   = btn;
    model_step(m, tok, btn);
  endtask

  task automatic cyc(input bit m, input bit tok, input bit btn);
    @(negedge clk);
    step(m, tok, btn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_rst(input string nm);
    n_tests++;
    if (got_vec() !== RST_OUT) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", nm, got_vec(), RST_OUT);
    end
  endtask

  // async reset mid-cycle, then release on a falling edge
  task automatic do_reset(input bit tok);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_rst("async_reset");
    expq.delete();
    m_ph = P_IDLE; m_el = 0; m_prev = 1'b0; m_tp = 1'b0; m_pp = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, tok, 1'b0);
  endtask

  initial begin : monitor
    logic [5:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        n_tests++;
        if (got_vec() !== e) begin
          n_fail++;
          $display("FAIL lights t=%0t got=%b exp=%b", $time, got_vec(), e);
        end
      end
    end
  end

  initial begin : driver
    int mleft;
    bit tok_r;
    repeat (2) @(negedge clk);
    check_rst("reset_state");
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    idle(100);

    cyc(1'b0, 1'b1, 1'b0);
    idle(45);

    cyc(1'b0, 1'b1, 1'b0);
    idle(8);
    cyc(1'b0, 1'b0, 1'b1);
    idle(50);

    cyc(1'b0, 1'b1, 1'b0);
    idle(16);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0);
    idle(30);

    cyc(1'b0, 1'b1, 1'b0);
    idle(8);
    cyc(1'b0, 1'b0, 1'b1);
    idle(20);
    do_reset(1'b0);
    idle(3);
    cyc(1'b0, 1'b1, 1'b0);
    idle(50);

    cyc(1'b0, 1'b1, 1'b0);
    idle(25);
    cyc(1'b0, 1'b1, 1'b0);
    idle(50);

    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1, 1'b0);
    idle(20);

    mleft = 0;
    tok_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) tok_r = ~tok_r;
      if (mleft == 0 && $urandom_range(0, 399) == 0)
        mleft = $urandom_range(1, 30);
      if ($urandom_range(0, 1499) == 0) do_reset(tok_r);
      cyc(mleft > 0, tok_r, $urandom_range(0, 29) == 0);
      if (mleft > 0) mleft--;
    end

    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d exp=0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
